// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: forwarding-select codes and sequencing-FSM states shared by the pipeline control blocks
package riscv_ctrl_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;
  typedef enum logic {ST_RUN = 1'b0, ST_MEMWAIT = 1'b1} state_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: picks the EX operand source for one ID source register, nearest producer first
module fwd_sel
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_de,
  input  logic       we_de,
  input  logic [4:0] rd_em,
  input  logic       we_em,
  output logic [1:0] sel
);
  always_comb
    sel = (rs != 5'd0 && we_de && rs == rd_de) ? FWD_EM :
          (rs != 5'd0 && we_em && rs == rd_em) ? FWD_MW : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing, EX forwarding selects, perf counters and memory-timeout flag
module hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE_RS1_ID,
  input  logic             USE_RS2_ID,
  input  logic [4:0]       RD_DE,
  input  logic             RegWrite_DE,
  input  logic             MemRead_DE,
  input  logic [4:0]       RD_EM,
  input  logic             RegWrite_EM,
  input  logic             isBranch_E,
  input  logic             DMEM_REQ_EM,
  input  logic             DMEM_ACK,
  output logic             STALL_IF,
  output logic             STALL_FD,
  output logic             STALL_DE,
  output logic             STALL_EM,
  output logic             FLUSH_FD,
  output logic             FLUSH_DE,
  output logic             BUBBLE_MW,
  output logic             REDIRECT_EN,
  output logic [1:0]       FWD_A_DE,
  output logic [1:0]       FWD_B_DE,
  output logic [CNT_W-1:0] CNT_STALL,
  output logic [CNT_W-1:0] CNT_FLUSH,
  output logic             ERR_TIMEOUT
);
  state_t      state;
  logic [15:0] wcnt;
  logic        freeze, br, hz, lu;
  logic [1:0]  fa, fb;
  // the ACK cycle of a wait is already live, so it is excluded from freeze
  always_comb begin
    freeze = !DMEM_ACK && (state == ST_MEMWAIT || DMEM_REQ_EM);
    br = !freeze && isBranch_E;
    hz = MemRead_DE && RegWrite_DE && RD_DE != 5'd0 &&
         ((USE_RS1_ID && RS1_ID == RD_DE) || (USE_RS2_ID && RS2_ID == RD_DE));
    lu = !freeze && !br && hz;
  end
  assign STALL_IF    = freeze || lu;
  assign STALL_FD    = freeze || lu;
  assign STALL_DE    = freeze;
  assign STALL_EM    = freeze;
  assign BUBBLE_MW   = freeze;
  assign FLUSH_FD    = br;
  assign FLUSH_DE    = br || lu;
  assign REDIRECT_EN = br;
  fwd_sel u_fa (.rs(RS1_ID), .rd_de(RD_DE), .we_de(RegWrite_DE), .rd_em(RD_EM), .we_em(RegWrite_EM), .sel(fa));
  fwd_sel u_fb (.rs(RS2_ID), .rd_de(RD_DE), .we_de(RegWrite_DE), .rd_em(RD_EM), .we_em(RegWrite_EM), .sel(fb));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RUN;
      wcnt        <= '0;
      ERR_TIMEOUT <= 1'b0;
      FWD_A_DE    <= FWD_RF;
      FWD_B_DE    <= FWD_RF;
      CNT_STALL   <= '0;
      CNT_FLUSH   <= '0;
    end else begin
      if (state == ST_RUN) begin
        if (freeze) begin
          state <= ST_MEMWAIT;
          wcnt  <= '0;
        end
      end else if (DMEM_ACK) begin
        state <= ST_RUN;
      end else if (wcnt == 16'(WAIT_MAX - 1)) begin
        state       <= ST_RUN;
        wcnt        <= '0;
        ERR_TIMEOUT <= 1'b1;
      end else begin
        wcnt <= wcnt + 16'd1;
      end
      FWD_A_DE  <= FLUSH_DE ? FWD_RF : STALL_DE ? FWD_A_DE : fa;
      FWD_B_DE  <= FLUSH_DE ? FWD_RF : STALL_DE ? FWD_B_DE : fb;
      CNT_STALL <= CNT_STALL + CNT_W'(STALL_IF);
      CNT_FLUSH <= CNT_FLUSH + CNT_W'(REDIRECT_EN);
    end
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core: detects load-use hazards, branch redirects and data-memory wait states, and drives per-stage stall/flush controls plus registered EX-stage forwarding selects. Sits beside the IF/ID/EX/MEM/WB pipeline-register bank in the top level, consuming register numbers and control bits from the ID, DE, EM and MW slices. Also keeps wrapping stall/flush performance counters and a sticky memory-timeout error flag.

## Interface
- WAIT_MAX, 255: max consecutive MEMWAIT cycles before timeout (1..65535)
- CNT_W, 32: width of performance counters
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- RS1_ID, RS2_ID  in  5  source register numbers of instruction in ID
- USE_RS1_ID, USE_RS2_ID  in  1  ID instruction actually reads rs1/rs2
- RD_DE  in  5  destination of instruction in EX
- RegWrite_DE, MemRead_DE  in  1  EX instruction writes RF / is a load
- RD_EM  in  5  destination of instruction in MEM
- RegWrite_EM  in  1  MEM instruction writes RF
- isBranch_E  in  1  taken branch/jump resolved in EX
- DMEM_REQ_EM  in  1  MEM stage has an outstanding data-memory access
- DMEM_ACK  in  1  data memory completes access this cycle
- STALL_IF, STALL_FD, STALL_DE, STALL_EM  out  1  hold PC / IF-ID / ID-EX / EX-MEM registers
- FLUSH_FD, FLUSH_DE  out  1  load NOP into IF-ID / ID-EX
- BUBBLE_MW  out  1  load NOP (RegWrite=0) into MEM-WB
- REDIRECT_EN  out  1  qualified PC redirect to IF
- FWD_A_DE, FWD_B_DE  out  2  EX operand select: 00 RF, 01 EM result, 10 MW result
- CNT_STALL, CNT_FLUSH  out  CNT_W  stall cycles / branch flushes
- ERR_TIMEOUT  out  1  sticky memory-timeout flag

## Operation
- FSM states: RUN, MEMWAIT. Reset → RUN.
- freeze = (state==MEMWAIT) or (DMEM_REQ_EM and not DMEM_ACK). Combinational.
- RUN→MEMWAIT when DMEM_REQ_EM=1, DMEM_ACK=0. MEMWAIT→RUN on DMEM_ACK=1 or timeout.
- freeze: STALL_IF/FD/DE/EM=1, BUBBLE_MW=1, all flushes 0, REDIRECT_EN=0; FWD regs hold. In MEMWAIT, ACK cycle itself is not frozen.
- Wait counter: cleared on entering MEMWAIT, increments each MEMWAIT cycle; reaching WAIT_MAX with no ACK sets ERR_TIMEOUT=1, returns to RUN (access abandoned). ERR_TIMEOUT clears only on RST.
- Branch (not frozen, isBranch_E=1): REDIRECT_EN=1, FLUSH_FD=1, FLUSH_DE=1; load-use suppressed (ID instruction is wrong-path). CNT_FLUSH += 1.
- Load-use (not frozen, no branch): MemRead_DE and RegWrite_DE and RD_DE!=0 and ((USE_RS1_ID and RS1_ID==RD_DE) or (USE_RS2_ID and RS2_ID==RD_DE)) → STALL_IF=1, STALL_FD=1, FLUSH_DE=1 for that cycle only.
- Priority: freeze > branch > load-use > run.
- Forwarding per operand, computed from ID fields: RS==RD_DE, RegWrite_DE, RS!=0 → 01; else RS==RD_EM, RegWrite_EM, RS!=0 → 10; else 00. Not gated by USE_* (harmless).
- FWD update: FLUSH_DE → 00; STALL_DE → hold; else load computed value.
- CNT_STALL += 1 every cycle STALL_IF=1 (freeze or load-use). Counters wrap modulo 2^CNT_W.

## Timing
- Stall/flush/bubble/REDIRECT_EN: combinational from inputs and state, same cycle.
- FWD_*_DE, counters, ERR_TIMEOUT, state: registered, update on the edge ending the cycle.
- Reset values: state RUN, FWD 00, counters 0, ERR_TIMEOUT 0, wait counter 0; combinational outputs 0 provided inputs idle.
- RST mid-MEMWAIT: next cycle RUN, counters and flag cleared.
- Branch arriving during freeze: held in frozen EX, REDIRECT_EN asserts first unfrozen cycle.
- DMEM_REQ_EM with DMEM_ACK same cycle: no freeze, no state change.

## Structure
- Shared package riscv_ctrl_pkg: FWD_RF=2'b00, FWD_EM=2'b01, FWD_MW=2'b10; state encoding ST_RUN, ST_MEMWAIT.
- One sub-module: fwd_sel (combinational per-operand compare); instantiate twice. Counters and FSM inline.

## Test plan
- ID reads x5, EX load to x5 → one cycle STALL_IF=STALL_FD=FLUSH_DE=1, CNT_STALL=1, next cycle FWD_A_DE=10.
- EX writes x3 (non-load), MEM writes x3, ID reads x3 → FWD_A_DE=01 (EM priority); RS=x0 with RD=x0 → 00.
- isBranch_E=1 together with load-use condition → FLUSH_FD=FLUSH_DE=REDIRECT_EN=1, no stall, CNT_FLUSH=1.
- DMEM_REQ_EM=1, ACK after 3 cycles → STALL_EM/BUBBLE_MW=1 for 3 cycles, CNT_STALL=3, RUN on ACK cycle; branch held in EX redirects after.
- WAIT_MAX=4, ACK never → ERR_TIMEOUT=1 after 4 MEMWAIT cycles, state RUN, flag sticky until RST.
- RST asserted during MEMWAIT → all outputs and counters at reset values next cycle.
